alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 61 ++++++
 rtl/alu_regfile.sv | 33 +++
 rtl/alu_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - opcodes, FSM states, instruction fields and flag order for alu_sequencer
package alu_sequencer_pkg;

   localparam int INSTR_W = 16;
   localparam int OP_W    = 5;
   localparam int REG_AW  = 3;
   localparam int IM_W    = 3;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 11;
   localparam int RD_MSB = 10;
   localparam int RD_LSB = 8;
   localparam int RS_MSB = 7;
   localparam int RS_LSB = 5;
   localparam int IM_MSB = 4;
   localparam int IM_LSB = 2;

   // flags output is {CF,ZF,SF,OF}
   localparam int FLAG_CF = 3;
   localparam int FLAG_ZF = 2;
   localparam int FLAG_SF = 1;
   localparam int FLAG_OF = 0;

   localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
   localparam logic [OP_W-1:0] OP_ADD   = 5'b00001;
   localparam logic [OP_W-1:0] OP_AND   = 5'b00010;
   localparam logic [OP_W-1:0] OP_SUB   = 5'b00011;
   localparam logic [OP_W-1:0] OP_OR    = 5'b00100;
   localparam logic [OP_W-1:0] OP_XOR   = 5'b00101;
   localparam logic [OP_W-1:0] OP_MOV   = 5'b00110;
   localparam logic [OP_W-1:0] OP_ADC   = 5'b00111;
   localparam logic [OP_W-1:0] OP_NOT   = 5'b01000;
   localparam logic [OP_W-1:0] OP_SAR   = 5'b01001;
   localparam logic [OP_W-1:0] OP_SLR   = 5'b01010;
   localparam logic [OP_W-1:0] OP_SAL   = 5'b01011;
   localparam logic [OP_W-1:0] OP_SLL   = 5'b01100;
   localparam logic [OP_W-1:0] OP_ROL   = 5'b01101;
   localparam logic [OP_W-1:0] OP_ROR   = 5'b01110;
   localparam logic [OP_W-1:0] OP_SHOWR = 5'b11111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   // Defined result-producing ops occupy one contiguous opcode range.
   function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_ROR);
   endfunction

   function automatic logic op_writes_flags(input logic [OP_W-1:0] op);
      return op_writes_reg(op) && (op != OP_MOV) && (op != OP_NOT);
   endfunction

   function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
      return (op != OP_NOP) && (op != OP_SHOWR) && !op_writes_reg(op);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file, two async read ports, one sync write port, async clear
module alu_regfile #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8,
   parameter int AW     = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr_a,
   input  logic [AW-1:0]     i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b
);

   logic [DATA_W-1:0] r_mem [NREGS];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state instruction sequencer driving an external ALU
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   input  logic              host_we,
   input  logic [2:0]        host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [2:0]        alu_im,
   output logic [4:0]        alu_op,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_cf,
   input  logic              alu_zf,
   input  logic              alu_sf,
   input  logic              alu_of,
   output logic [3:0]        flags,
   output logic              done,
   output logic              illegal,
   output logic              show_valid,
   output logic [DATA_W-1:0] show_data
);

   state_t              r_state;
   logic [OP_W-1:0]     r_op;
   logic [REG_AW-1:0]   r_rd;
   logic [REG_AW-1:0]   r_rs;
   logic [IM_W-1:0]     r_im;
   logic [DATA_W-1:0]   r_res;
   logic [3:0]          r_alu_flags;
   logic [3:0]          r_flags;
   logic                r_done;
   logic                r_illegal;
   logic                r_show_valid;
   logic [DATA_W-1:0]   r_show_data;

   logic                w_idle;
   logic                w_busy;
   logic                w_accept;
   logic                w_we;
   logic [REG_AW-1:0]   w_waddr;
   logic [DATA_W-1:0]   w_wdata;
   logic [DATA_W-1:0]   w_rdata_a;
   logic [DATA_W-1:0]   w_rdata_b;
   logic                w_unused;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_busy   = (r_state == ST_READ) || (r_state == ST_EXEC);
   assign w_accept = instr_valid && w_idle;
   assign w_unused = ^instr[1:0];

   // Host preload and writeback share the single write port; they live in different states.
   assign w_we    = (w_idle && host_we) || ((r_state == ST_WB) && op_writes_reg(r_op));
   assign w_waddr = w_idle ? host_addr  : r_rd;
   assign w_wdata = w_idle ? host_wdata : r_res;

   alu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .AW     (REG_AW)
   ) u_regfile (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (r_rd),
      .i_raddr_b (r_rs),
      .o_rdata_a (w_rdata_a),
      .o_rdata_b (w_rdata_b)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_op         <= OP_NOP;
         r_rd         <= '0;
         r_rs         <= '0;
         r_im         <= '0;
         r_res        <= '0;
         r_alu_flags  <= '0;
         r_flags      <= '0;
         r_done       <= 1'b0;
         r_illegal    <= 1'b0;
         r_show_valid <= 1'b0;
         r_show_data  <= '0;
      end else begin
         r_done       <= 1'b0;
         r_illegal    <= 1'b0;
         r_show_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op    <= instr[OP_MSB:OP_LSB];
                  r_rd    <= instr[RD_MSB:RD_LSB];
                  r_rs    <= instr[RS_MSB:RS_LSB];
                  r_im    <= instr[IM_MSB:IM_LSB];
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_res                <= alu_res;
               r_alu_flags[FLAG_CF] <= alu_cf;
               r_alu_flags[FLAG_ZF] <= alu_zf;
               r_alu_flags[FLAG_SF] <= alu_sf;
               r_alu_flags[FLAG_OF] <= alu_of;
               r_state              <= ST_WB;
            end
            ST_WB: begin
               r_done    <= 1'b1;
               r_illegal <= op_is_illegal(r_op);
               if (op_writes_flags(r_op)) begin
                  r_flags <= r_alu_flags;
               end
               if (r_op == OP_SHOWR) begin
                  r_show_valid <= 1'b1;
                  r_show_data  <= w_rdata_a;
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign instr_ready = w_idle;
   assign alu_op      = w_busy ? r_op      : OP_NOP;
   assign alu_im      = w_busy ? r_im      : '0;
   assign alu_in1     = w_busy ? w_rdata_a : '0;
   assign alu_in2     = w_busy ? w_rdata_b : '0;
   assign flags       = r_flags;
   assign done        = r_done;
   assign illegal     = r_illegal;
   assign show_valid  = r_show_valid;
   assign show_data   = r_show_data;

endmodule
